stack_arbiter: RTL and testbench
================================

# stack_arbiter

Shares one `stack` instance (DEPTH × WIDTH, single-cycle push/pop strobes, pop data registered one cycle after the strobe) between NREQ requesters. It performs round-robin arbitration and issues exactly one stack operation per grant. It keeps its own occupancy count, because the stack's full/empty flags are registered and lag by a cycle, and it rejects overflowing pushes and underflowing pops with an error acknowledge. It sits between client logic and the stack; the stack's push, pop and data_in are driven only by this block.

## Interface
- DEPTH, 8, stack depth; must match the attached stack
- WIDTH, 8, data width
- NREQ, 2, number of requesters (2..8)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset; shared with the stack
- req  in  NREQ  per-port request level; held until that port's ack
- req_op  in  NREQ  per-port op: 1 = push, 0 = pop; stable while req high
- req_data  in  NREQ*WIDTH  per-port push data, port i at [i*WIDTH +: WIDTH]
- ack  out  NREQ  one-cycle completion pulse, one-hot or zero
- rsp_data  out  WIDTH  pop result, valid only with ack of a successful pop, else 0
- rsp_err  out  1  qualifies ack: 1 = push rejected (full) or pop rejected (empty)
- stk_push  out  1  to stack push
- stk_pop  out  1  to stack pop
- stk_data_in  out  WIDTH  to stack data_in
- stk_data_out  in  WIDTH  from stack data_out
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- busy  out  1  FSM not in IDLE

## Operation
- All outputs are registered. Reset values: ack=0, rsp_data=0, rsp_err=0, stk_push=0, stk_pop=0, stk_data_in=0, count=0, busy=0, FSM=IDLE, rr pointer=NREQ-1 (so port 0 wins the first tie).
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE, any req high:
  - Pick the winner by round-robin. Priority starts at (last winner + 1) mod NREQ.
  - Latch the winner's id, op and data, update the pointer, and go to ISSUE.
- ISSUE, push with count < DEPTH: stk_push=1, stk_data_in = latched data, ack[id]=1, rsp_err=0, count+1, then IDLE.
- ISSUE, push with count == DEPTH: no strobe, ack[id]=1, rsp_err=1, count unchanged, then IDLE.
- ISSUE, pop with count > 0: stk_pop=1, count−1, then CAPTURE.
- ISSUE, pop with count == 0: no strobe, ack[id]=1, rsp_err=1, rsp_data=0, then IDLE.
- CAPTURE: stk_data_out is valid; register it into rsp_data and go to RESP.
- RESP: ack[id]=1, rsp_err=0, rsp_data = popped value, then IDLE.
- Requests are ignored outside IDLE. A port whose req drops before its ack is serviced anyway; the ack still fires.
- count never uses the stack's full/empty flags. The count width holds DEPTH exactly, with no wrap.

## Timing
- Request sampled in IDLE at cycle 0.
  - Push: strobe and ack at cycle 1; next grant possible at cycle 2. Throughput is 1 push per 2 cycles.
  - Pop: strobe at cycle 1, capture at cycle 2, ack with data at cycle 3, IDLE at cycle 4.
  - Errors: ack at cycle 1.
- A requester that sees ack at cycle N may present a new request from cycle N+1; it is sampled when the FSM is next in IDLE.
- Every strobe is a single cycle. stk_push and stk_pop are never high together, and stk_pop is high only when count > 0.
- rst asserted in any state takes effect at the next edge: FSM=IDLE, count=0, all outputs at reset values, and any in-flight ack is dropped. The stack is reset in the same cycle, so contents are discarded consistently.

## Structure
- Package `stack_pkg`:
  - FSM state enum
  - op encoding constants OP_PUSH=1'b1, OP_POP=1'b0
  - count-width function
- Sub-module `rr_arbiter` (NREQ): combinational one-hot grant from req and the pointer, plus a registered pointer update on an accept strobe.
- Top level: FSM, latches, occupancy counter and output registers; the bench instantiates it with `stack`.

## Test plan
- Reset, then port 0 pushes 0xA5 → stk_push pulse and ack[0] at cycle 1, rsp_err=0, count=1.
- After the above, port 1 pops → ack[1] at cycle 3, rsp_data=0xA5, rsp_err=0, count=0.
- Pop with count=0 → ack at cycle 1, rsp_err=1, rsp_data=0, no stk_pop.
- Push 8 values (DEPTH=8), then a 9th push → 9th ack has rsp_err=1, count stays 8, no stk_push. Then 8 pops return the values in LIFO order.
- Ports 0 and 1 hold req continuously, both pushing → grants alternate 0,1,0,1 starting with port 0; acks never overlap.
- Assert rst during CAPTURE of a pop → no ack, count=0, busy=0 next cycle, and a subsequent pop returns rsp_err=1.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and helpers for the stack arbiter: FSM states, op encoding, count width.
package stack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances to the winner on accept.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic                     accept,
  output logic [NREQ-1:0]          grant_c,
  output logic [$clog2(NREQ)-1:0]  gnt_id_c
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] ptr;
  logic          found;
  int unsigned   idx;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    grant_c  = '0;
    gnt_id_c = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = (32'(ptr) + off) % NREQ;
      if (!found && req[IW'(idx)]) begin
        found             = 1'b1;
        grant_c[IW'(idx)] = 1'b1;
        gnt_id_c          = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IW'(NREQ - 1);
    end else if (accept) begin
      ptr <= gnt_id_c;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin front end for a shared stack: one stack op per grant, own occupancy count,
// error acknowledge on overflowing push or underflowing pop.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_op,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           ack,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic                      stk_push,
  output logic                      stk_pop,
  output logic [WIDTH-1:0]          stk_data_in,
  input  logic [WIDTH-1:0]          stk_data_out,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      busy
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned IW = $clog2(NREQ);

  state_e            state, state_n;
  logic [IW-1:0]     id_q, id_n;
  logic              op_q, op_n;
  logic [CW-1:0]     count_n;
  logic [NREQ-1:0]   ack_n;
  logic [WIDTH-1:0]  rsp_data_n;
  logic              rsp_err_n;
  logic              push_n;
  logic              pop_n;
  logic [WIDTH-1:0]  din_n;
  logic              accept_c;
  logic [NREQ-1:0]   grant_c;
  logic [IW-1:0]     gnt_id_c;
  logic              win_op_c;
  logic [WIDTH-1:0]  win_data_c;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .accept   (accept_c),
    .grant_c  (grant_c),
    .gnt_id_c (gnt_id_c)
  );

  assign win_op_c   = req_op[gnt_id_c];
  assign win_data_c = req_data[32'(gnt_id_c) * WIDTH +: WIDTH];

  // Outputs are computed one state ahead so they are registered alongside the state.
  always_comb begin
    state_n    = state;
    id_n       = id_q;
    op_n       = op_q;
    count_n    = count;
    ack_n      = '0;
    rsp_data_n = '0;
    rsp_err_n  = 1'b0;
    push_n     = 1'b0;
    pop_n      = 1'b0;
    din_n      = stk_data_in;
    accept_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          accept_c = 1'b1;
          id_n     = gnt_id_c;
          op_n     = win_op_c;
          state_n  = ST_ISSUE;
          if (win_op_c == OP_PUSH) begin
            ack_n = grant_c;
            if (count < CW'(DEPTH)) begin
              push_n  = 1'b1;
              din_n   = win_data_c;
              count_n = count + CW'(1);
            end else begin
              rsp_err_n = 1'b1;
            end
          end else if (count != '0) begin
            pop_n   = 1'b1;
            count_n = count - CW'(1);
          end else begin
            ack_n     = grant_c;
            rsp_err_n = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_n = (op_q == OP_POP && !rsp_err) ? ST_CAPTURE : ST_IDLE;
      end
      ST_CAPTURE: begin
        ack_n      = NREQ'(1) << id_q;
        rsp_data_n = stk_data_out;
        state_n    = ST_RESP;
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      id_q        <= '0;
      op_q        <= OP_POP;
      count       <= '0;
      ack         <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_data_in <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      id_q        <= id_n;
      op_q        <= op_n;
      count       <= count_n;
      ack         <= ack_n;
      rsp_data    <= rsp_data_n;
      rsp_err     <= rsp_err_n;
      stk_push    <= push_n;
      stk_pop     <= pop_n;
      stk_data_in <= din_n;
      busy        <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural stack attached to its stack ports.
module tb_stack_arbiter;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned W     = 8;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              stk_push;
  logic              stk_pop;
  logic [W-1:0]      stk_data_in;
  logic [W-1:0]      stk_data_out;
  logic [CW-1:0]     count;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  stack_arbiter #(.DEPTH(DEPTH), .WIDTH(W), .NREQ(NREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_op       (req_op),
    .req_data     (req_data),
    .ack          (ack),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .count        (count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: pop data registered one cycle after the strobe.
  logic [W-1:0] mem [DEPTH];
  int sp;
  always @(posedge clk) begin
    if (rst) begin
      sp           <= 0;
      stk_data_out <= '0;
    end else if (stk_push && sp < int'(DEPTH)) begin
      mem[sp] <= stk_data_in;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_data_out <= mem[sp-1];
      sp           <= sp - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample after the edge; strobe exclusivity and ack one-hotness always hold.
  task automatic tick;
    @(posedge clk);
    #1;
    check("push_pop_excl", 32'(stk_push & stk_pop), 32'd0);
    check("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
  endtask

  task automatic do_push(input int port, input logic [W-1:0] data, input logic exp_err,
                         input int exp_count);
    req[port]            = 1'b1;
    req_op[port]         = 1'b1;
    req_data[port*W +: W] = data;
    tick;
    check("push_ack", 32'(ack), 32'(2'(1) << port));
    check("push_err", 32'(rsp_err), 32'(exp_err));
    check("push_strobe", 32'(stk_push), 32'(!exp_err));
    if (!exp_err) check("push_din", 32'(stk_data_in), 32'(data));
    check("push_count", 32'(count), 32'(exp_count));
    req[port] = 1'b0;
    tick;
    check("push_idle_ack", 32'(ack), 32'd0);
    check("push_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_pop(input int port, input logic exp_err, input logic [W-1:0] exp_data,
                        input int exp_count);
    req[port]    = 1'b1;
    req_op[port] = 1'b0;
    tick;
    if (exp_err) begin
      check("pop_err_ack", 32'(ack), 32'(2'(1) << port));
      check("pop_err_flag", 32'(rsp_err), 32'd1);
      check("pop_err_data", 32'(rsp_data), 32'd0);
      check("pop_err_strobe", 32'(stk_pop), 32'd0);
      check("pop_err_count", 32'(count), 32'(exp_count));
      req[port] = 1'b0;
      tick;
      check("pop_err_busy", 32'(busy), 32'd0);
    end else begin
      check("pop_strobe", 32'(stk_pop), 32'd1);
      check("pop_issue_ack", 32'(ack), 32'd0);
      check("pop_count", 32'(count), 32'(exp_count));
      tick;
      check("pop_capture_ack", 32'(ack), 32'd0);
      check("pop_capture_strobe", 32'(stk_pop), 32'd0);
      tick;
      check("pop_ack", 32'(ack), 32'(2'(1) << port));
      check("pop_data", 32'(rsp_data), 32'(exp_data));
      check("pop_rsp_err", 32'(rsp_err), 32'd0);
      req[port] = 1'b0;
      tick;
      check("pop_idle_busy", 32'(busy), 32'd0);
      check("pop_idle_ack", 32'(ack), 32'd0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_op   = '0;
    req_data = '0;
    tick;
    tick;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_push", 32'(stk_push), 32'd0);
    check("rst_pop", 32'(stk_pop), 32'd0);
    check("rst_din", 32'(stk_data_in), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Basic push then pop from the other port, then underflow.
    do_push(0, 8'hA5, 1'b0, 1);
    do_pop(1, 1'b0, 8'hA5, 0);
    do_pop(0, 1'b1, 8'h00, 0);

    // Fill, overflow, drain in LIFO order.
    for (int i = 0; i < int'(DEPTH); i++) do_push(i % 2, W'(8'h10 + i), 1'b0, i + 1);
    do_push(1, 8'hEE, 1'b1, DEPTH);
    for (int i = 0; i < int'(DEPTH); i++) do_pop(i % 2, 1'b0, W'(8'h17 - i), DEPTH - 1 - i);

    // Both ports request continuously: grants alternate starting with port 0.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req_op   = 2'b11;
    req_data = {8'h31, 8'h30};
    req      = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("rr_ack", 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd2);
      check("rr_din", 32'(stk_data_in), (k % 2 == 0) ? 32'h30 : 32'h31);
      req = 2'b11;
      tick;
      check("rr_gap_ack", 32'(ack), 32'd0);
      if (k == 3) req = 2'b00;
    end
    check("rr_count", 32'(count), 32'd4);

    // Reset while a pop is in CAPTURE drops the ack and empties everything.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    do_push(0, 8'h5A, 1'b0, 1);
    req[1]    = 1'b1;
    req_op[1] = 1'b0;
    tick;
    check("rstcap_pop", 32'(stk_pop), 32'd1);
    tick;
    check("rstcap_capture_ack", 32'(ack), 32'd0);
    rst = 1'b1;
    req = '0;
    tick;
    check("rstcap_ack", 32'(ack), 32'd0);
    check("rstcap_count", 32'(count), 32'd0);
    check("rstcap_busy", 32'(busy), 32'd0);
    check("rstcap_data", 32'(rsp_data), 32'd0);
    rst = 1'b0;
    tick;
    check("rstcap_late_ack", 32'(ack), 32'd0);
    do_pop(1, 1'b1, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
